// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one main-memory port between an I-cache line
// refill (WORDS-beat burst) and a single-word data load/store.
// Optional feature: define ARB_RR_EN for round-robin arbitration on conflict;
// otherwise the data side always wins a conflict.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WORDS  = 8,
  localparam int IDX_W = $clog2(WORDS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_ic_req,
  input  logic [ADDR_W-1:0] i_ic_addr,
  output logic              o_ic_wvalid,
  output logic [IDX_W-1:0]  o_ic_widx,
  output logic [DATA_W-1:0] o_ic_wdata,
  output logic              o_ic_done,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  input  logic [3:0]        i_d_be,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_be,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int OFF_W = IDX_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IFILL = 2'd1,
    ST_DACC  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [IDX_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_be;
  logic                w_grantD;
  logic                w_grantI;
  logic                w_lastBeat;

`ifdef ARB_RR_EN
  logic                r_lastGrantD;

  // On a conflict the side that was not served last wins; otherwise whoever asks.
  always_comb begin
    w_grantD = i_d_req & (~i_ic_req | ~r_lastGrantD);
    w_grantI = i_ic_req & ~w_grantD;
  end

  // Remember which side was granted most recently (reset favours data next).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_lastGrantD <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (w_grantD) begin
        r_lastGrantD <= 1'b1;
      end else if (w_grantI) begin
        r_lastGrantD <= 1'b0;
      end
    end
  end
`else
  // Fixed priority: a pending data request always beats a refill request.
  always_comb begin
    w_grantD = i_d_req;
    w_grantI = i_ic_req & ~i_d_req;
  end
`endif

  assign w_lastBeat = (r_cnt == LAST_IDX);

  // State register; an asynchronous reset abandons any transfer in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: grant from IDLE, return to IDLE after the final memory ack.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grantD) begin
          w_nextState = ST_DACC;
        end else if (w_grantI) begin
          w_nextState = ST_IFILL;
        end
      end
      ST_IFILL: begin
        if (i_mem_ack && w_lastBeat) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_DACC: begin
        if (i_mem_ack) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Capture the winner's request fields at grant and count refill beats.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (w_grantD) begin
          r_addr  <= i_d_addr;
          r_we    <= i_d_we;
          r_wdata <= i_d_wdata;
          r_be    <= i_d_be;
        end else if (w_grantI) begin
          r_addr  <= i_ic_addr;
          r_we    <= 1'b0;
          r_wdata <= '0;
          r_be    <= '0;
        end
      end
      if (r_state == ST_IFILL && i_mem_ack) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Drive the memory port from latched fields and route responses back.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_be    = '0;
    o_ic_wvalid = 1'b0;
    o_ic_widx   = '0;
    o_ic_wdata  = '0;
    o_ic_done   = 1'b0;
    o_d_ack     = 1'b0;
    o_d_rdata   = '0;
    case (r_state)
      ST_IFILL: begin
        o_mem_req  = 1'b1;
        o_mem_addr = {r_addr[ADDR_W-1:OFF_W], r_cnt, 2'b00};
        if (i_mem_ack) begin
          o_ic_wvalid = 1'b1;
          o_ic_widx   = r_cnt;
          o_ic_wdata  = i_mem_rdata;
          o_ic_done   = w_lastBeat;
        end
      end
      ST_DACC: begin
        o_mem_req   = 1'b1;
        o_mem_we    = r_we;
        o_mem_addr  = r_addr;
        o_mem_wdata = r_wdata;
        o_mem_be    = r_be;
        if (i_mem_ack) begin
          o_d_ack   = 1'b1;
          o_d_rdata = r_we ? '0 : i_mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule
